absorb_load_pad_stage: RTL and testbench

- Input-side counterpart of the permute/dump datapath: it writes blocks where the dump path reads them.
- Accepts a message as a stream of w-bit words plus a command (mode, input size, output size).
- Packs the words into rate blocks with a SIPO buffer and applies SHAKE padding: 0x1F domain byte, zero fill, 0x80 final bit.
- Hands each block to the permute stage over a valid/ready handshake, together with last-block and control sideband.

---
 rtl/absorb_load_pad_stage.sv | 219 +++++++++++++++++++++
 tb/tb_absorb_load_pad_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/absorb_load_pad_stage.sv
// absorb_load_pad_stage
// Packs a byte-granular message, delivered as 64-bit words, into SHAKE rate
// blocks. SHAKE padding is applied on the way: a 0x1F domain byte, zero
// fill, then 0x80 in the last byte of the block. Each block is offered to
// the permute stage over a valid/ready handshake.
// Word i of a block sits at rate_output[RATE_WIDTH-1-i*w -: w], so SHAKE256
// blocks of 17 words occupy the upper 1088 bits.

module absorb_load_pad_stage #(
  parameter int w          = 64,
  parameter int RATE_WIDTH = 1344
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            operation_mode_in,
  input  logic [31:0]           input_size_in,
  input  logic [31:0]           output_size_in,
  input  logic [w-1:0]          data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [RATE_WIDTH-1:0] rate_output,
  output logic                  block_valid,
  input  logic                  block_ready,
  output logic                  last_block,
  output logic [1:0]            operation_mode_out,
  output logic [31:0]           output_size_out
);

  localparam int         NWORDS            = RATE_WIDTH / w;
  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PAD     = 3'd2,
    S_PAD_END = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [31:0]               osize_q, osize_d;
  logic [31:0]               rem_q, rem_d;
  logic [4:0]                idx_q, idx_d;
  logic [NWORDS-1:0][w-1:0]  blk_q, blk_d;
  logic                      last_q, last_d;
  logic                      pad_pending_q, pad_pending_d;

  logic [4:0]                n_words_s;
  logic                      word_final_s;
  logic                      word_partial_s;
  logic                      at_end_s;

  // Keep b message bytes, put the 0x1F domain byte at position b, zero above it.
  function automatic logic [63:0] pad_partial_word(input logic [63:0] data,
                                                   input logic [2:0]  nbytes);
    logic [63:0] r;
    r = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(nbytes)) begin
        r[8*k +: 8] = data[8*k +: 8];
      end else if (k == int'(nbytes)) begin
        r[8*k +: 8] = 8'h1F;
      end else begin
        r[8*k +: 8] = 8'h00;
      end
    end
    return r;
  endfunction

  // An unrecognised mode is treated as SHAKE128 (21-word block).
  assign n_words_s      = (mode_q == SHAKE256_MODE_VEC) ? 5'd17 : 5'd21;
  assign word_final_s   = (rem_q <= 32'd64);
  assign word_partial_s = (rem_q < 32'd64);
  assign at_end_s       = (idx_q == (n_words_s - 5'd1));

  // Next-state logic: command latch, word packing, padding and block handoff.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    osize_d       = osize_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    blk_d         = blk_q;
    last_d        = last_q;
    pad_pending_d = pad_pending_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d        = operation_mode_in;
          osize_d       = output_size_in;
          rem_d         = input_size_in & 32'hFFFF_FFF8;
          blk_d         = '0;
          idx_d         = 5'd0;
          last_d        = 1'b0;
          pad_pending_d = 1'b0;
          if ((input_size_in & 32'hFFFF_FFF8) != 32'd0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_PAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (data_in_valid) begin
          if (word_partial_s) begin
            blk_d[idx_q] = pad_partial_word(data_in, rem_q[5:3]);
          end else begin
            blk_d[idx_q] = data_in;
          end
          rem_d = word_final_s ? 32'd0 : (rem_q - 32'd64);
          if (word_final_s) begin
            if (!at_end_s) begin
              // 0x1F is already in place for a partial word; a full word
              // needs the domain byte in the following word.
              idx_d   = idx_q + 5'd1;
              state_d = word_partial_s ? S_PAD_END : S_PAD;
            end else if (word_partial_s) begin
              blk_d[idx_q][63:56] = blk_d[idx_q][63:56] | 8'h80;
              last_d  = 1'b1;
              state_d = S_HOLD;
            end else begin
              // Message ends exactly on a block boundary: padding goes
              // into an extra block after this one is taken.
              last_d        = 1'b0;
              pad_pending_d = 1'b1;
              state_d       = S_HOLD;
            end
          end else if (at_end_s) begin
            last_d  = 1'b0;
            state_d = S_HOLD;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_PAD: begin
        blk_d[idx_q][7:0] = 8'h1F;
        state_d           = S_PAD_END;
      end
      S_PAD_END: begin
        blk_d[n_words_s - 5'd1][63:56] = blk_q[n_words_s - 5'd1][63:56] | 8'h80;
        last_d  = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (block_ready) begin
          if (pad_pending_q) begin
            blk_d         = '0;
            idx_d         = 5'd0;
            pad_pending_d = 1'b0;
            state_d       = S_PAD;
          end else if (last_q) begin
            state_d = S_IDLE;
          end else begin
            blk_d   = '0;
            idx_d   = 5'd0;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= SHAKE128_MODE_VEC;
      osize_q       <= 32'd0;
      rem_q         <= 32'd0;
      idx_q         <= 5'd0;
      blk_q         <= '0;
      last_q        <= 1'b0;
      pad_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      osize_q       <= osize_d;
      rem_q         <= rem_d;
      idx_q         <= idx_d;
      blk_q         <= blk_d;
      last_q        <= last_d;
      pad_pending_q <= pad_pending_d;
    end
  end

  // Map buffer words onto the rate bus, forcing words beyond the block size to zero.
  always_comb begin
    rate_output = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (i < int'(n_words_s)) begin
        rate_output[RATE_WIDTH-1-i*w -: w] = blk_q[i];
      end else begin
        rate_output[RATE_WIDTH-1-i*w -: w] = '0;
      end
    end
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign data_in_ready      = (state_q == S_LOAD);
  assign block_valid        = (state_q == S_HOLD);
  assign last_block         = (state_q == S_HOLD) && last_q;
  assign operation_mode_out = mode_q;
  assign output_size_out    = osize_q;

endmodule

// File: tb/tb_absorb_load_pad_stage.sv
// Randomized bench for absorb_load_pad_stage. The reference model builds the
// padded message as a flat byte array (message, 0x1F, zeros, final |0x80),
// then slices it into rate blocks and compares every block handed over.

module tb_absorb_load_pad_stage;

  localparam logic [1:0] M128 = 2'b00;
  localparam logic [1:0] M256 = 2'b01;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    operation_mode_in;
  logic [31:0]   input_size_in;
  logic [31:0]   output_size_in;
  logic [63:0]   data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [1343:0] rate_output;
  logic          block_valid;
  logic          block_ready;
  logic          last_block;
  logic [1:0]    operation_mode_out;
  logic [31:0]   output_size_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wd  [0:63];
  logic [7:0]  pb  [0:1023];
  int          lat [0:15];
  int          nn;
  int          rb;

  absorb_load_pad_stage dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .operation_mode_in  (operation_mode_in),
    .input_size_in      (input_size_in),
    .output_size_in     (output_size_in),
    .data_in            (data_in),
    .data_in_valid      (data_in_valid),
    .data_in_ready      (data_in_ready),
    .rate_output        (rate_output),
    .block_valid        (block_valid),
    .block_ready        (block_ready),
    .last_block         (last_block),
    .operation_mode_out (operation_mode_out),
    .output_size_out    (output_size_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected word j of block b, taken from the padded byte stream.
  function automatic logic [63:0] exp_word(input int b, input int j);
    logic [63:0] r;
    r = 64'd0;
    if (j < nn) begin
      for (int k = 0; k < 8; k++) r[8*k +: 8] = pb[b*rb + 8*j + k];
    end
    return r;
  endfunction

  function automatic logic [63:0] rate_word(input int j);
    return rate_output[1343 - j*64 -: 64];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"},   cmd_ready, 1'b1);
    check_eq({tag, "_din_ready"},   data_in_ready, 1'b0);
    check_eq({tag, "_block_valid"}, block_valid, 1'b0);
    check_eq({tag, "_last"},        last_block, 1'b0);
    check_eq({tag, "_mode"},        operation_mode_out, 2'b00);
    check_eq({tag, "_osize"},       output_size_out, 32'd0);
    check_eq({tag, "_rate_nonzero"}, |rate_output, 1'b0);
  endtask

  task automatic run_msg(input logic [1:0] mode, input int lbits, input logic [31:0] osize,
                         input int bp_min, input int bp_max,
                         input bit fixed, input logic [63:0] fixed_w0);
    int L, nwords, total, nblk, ev, wi, bi, cyc, wait_n;
    bit seen;
    nn     = (mode == M256) ? 17 : 21;
    rb     = nn * 8;
    L      = lbits / 8;
    nwords = (L + 7) / 8;
    total  = ((L + rb) / rb) * rb;
    nblk   = total / rb;
    for (int i = 0; i < nwords; i++) wd[i] = {$urandom, $urandom};
    if (fixed) wd[0] = fixed_w0;
    for (int p = 0; p < total; p++) pb[p] = (p < L) ? wd[p/8][8*(p%8) +: 8] : 8'h00;
    pb[L]       = 8'h1F;
    pb[total-1] = pb[total-1] | 8'h80;
    // Cycles from the block's last triggering event to block_valid: one,
    // plus one for each pad byte that lands outside any message word.
    for (int b = 0; b < nblk; b++) begin
      lat[b] = 1 + (((L / rb) == b && (L / 8) >= nwords) ? 1 : 0)
                 + ((((total - 1) / rb) == b && ((total - 1) / 8) >= nwords) ? 1 : 0);
    end

    @(negedge clk);
    cmd_valid         = 1'b1;
    operation_mode_in = mode;
    input_size_in     = lbits;
    output_size_in    = osize;
    check_eq("cmd_ready_idle", cmd_ready, 1'b1);
    ev = 0; wi = 0; bi = 0; cyc = 0; seen = 1'b0; wait_n = 0;
    @(negedge clk);
    while (bi < nblk && cyc < 3000) begin
      ev++;
      cyc++;
      data_in_valid = 1'b0;
      block_ready   = 1'b0;
      // Stray commands while busy must be ignored.
      cmd_valid         = ($urandom_range(0, 3) == 0);
      operation_mode_in = 2'($urandom_range(0, 3));
      input_size_in     = $urandom;
      output_size_in    = $urandom;
      if (block_valid) begin
        if (!seen) begin
          check_eq($sformatf("latency_b%0d", bi), ev, lat[bi]);
          seen   = 1'b1;
          wait_n = $urandom_range(bp_min, bp_max);
        end
        check_eq("hold_no_din_ready", data_in_ready, 1'b0);
        if (wait_n == 0) begin
          for (int j = 0; j < 21; j++)
            check_eq($sformatf("b%0d_w%0d", bi, j), rate_word(j), exp_word(bi, j));
          check_eq($sformatf("b%0d_last", bi), last_block, (bi == nblk - 1));
          check_eq("mode_out", operation_mode_out, mode);
          check_eq("osize_out", output_size_out, osize);
          block_ready = 1'b1;
          bi++;
          seen = 1'b0;
          ev   = 0;
        end else begin
          check_eq("stall_w0", rate_word(0), exp_word(bi, 0));
          check_eq("stall_wlast", rate_word(nn - 1), exp_word(bi, nn - 1));
          check_eq("stall_last", last_block, (bi == nblk - 1));
          wait_n--;
        end
      end else if (data_in_ready) begin
        if (wi < nwords) begin
          if ($urandom_range(0, 3) != 0) begin
            data_in       = wd[wi];
            data_in_valid = 1'b1;
            wi++;
            ev = 0;
          end
        end else begin
          check_eq("no_extra_word_request", data_in_ready, 1'b0);
        end
      end
      @(negedge clk);
    end
    cmd_valid     = 1'b0;
    data_in_valid = 1'b0;
    block_ready   = 1'b0;
    check_eq("blocks_seen", bi, nblk);
    check_eq("words_sent", wi, nwords);
    check_eq("back_to_idle", cmd_ready, 1'b1);
    check_eq("idle_block_valid", block_valid, 1'b0);
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    cmd_valid         = 1'b1;
    operation_mode_in = M256;
    input_size_in     = 32'd2000;
    output_size_in    = 32'h0000_1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_eq("midload_din_ready", data_in_ready, 1'b1);
      data_in       = {$urandom, $urandom};
      data_in_valid = 1'b1;
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    check_eq("midload_mode_latched", operation_mode_out, M256);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midload_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    cmd_valid         = 1'b0;
    operation_mode_in = 2'b00;
    input_size_in     = 32'd0;
    output_size_in    = 32'd0;
    data_in           = 64'd0;
    data_in_valid     = 1'b0;
    block_ready       = 1'b0;
    #12 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_msg(M128, 0,    32'd256,  0, 2, 1'b0, 64'd0);
    run_msg(M256, 24,   32'd512,  0, 2, 1'b1, 64'h0000_0000_00CC_BBAA);
    run_msg(M256, 1080, 32'd100,  0, 2, 1'b0, 64'd0);
    run_msg(M256, 1088, 32'd64,   0, 2, 1'b0, 64'd0);
    run_msg(M128, 1600, 32'd1000, 5, 5, 1'b0, 64'd0);
    reset_mid_load();
    run_msg(M128, 1347, 32'd7,    0, 1, 1'b0, 64'd0);

    for (int t = 0; t < 20; t++) begin
      run_msg(2'($urandom_range(0, 3)), $urandom_range(0, 3000), $urandom,
              0, 3, 1'b0, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
